// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide unit: funct codes, FSM states,
// iteration-step modes and the divide-by-zero LO fill value.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // LO is filled with this bit on divide by zero, whatever the width.
  localparam logic DIVZERO_LO_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  typedef enum logic {
    SM_MUL = 1'b0,
    SM_DIV = 1'b1
  } step_mode_e;

  function automatic logic is_muldiv(input logic [5:0] fn);
    return fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction

  function automatic logic is_known(input logic [5:0] fn);
    return is_muldiv(fn) || (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Datapath <-> multiply/divide unit bundle: instruction in, HI/LO and
// handshake status out.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alucontrol, srca, srcb,
    input  busy, done, stall, result, hi, lo
  );

  modport slave (
    input  start, alucontrol, srca, srcb,
    output busy, done, stall, result, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: add-accumulate for multiply,
// restoring shift-subtract (one quotient bit) for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] operand,
  input  step_mode_e         mode,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               qbit
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    // Only the low WIDTH bits matter: when the subtract succeeds the true
    // difference is below the divisor.
    diff     = rem_sh[WIDTH-1:0] - operand[WIDTH-1:0];
    qbit     = 1'b0;
    acc_next = acc + operand;
    if (mode == SM_DIV) begin
      qbit     = (rem_sh >= {1'b0, operand[WIDTH-1:0]});
      acc_next = {(qbit ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MT*/MF* access.
// Optional MULDIV_EARLY_TERM_EN: multiply finishes once the multiplier runs out.
//
//   state   | meaning
//   IDLE    | waiting; MT*/MF* serviced, mul/div accepted
//   MUL     | shift-add, one multiplier bit per edge
//   DIV     | restoring divide, one quotient bit per edge
//   FIX     | sign correction, HI/LO write, done next cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  bus
);

  state_e             state_q, state_n;
  logic [2*WIDTH-1:0] acc_q, opnd_q, step_acc, step_opnd, prod;
  logic [WIDTH-1:0]   mplr_q, hi_q, lo_q, abs_a, abs_b, quo, rem, fix_hi, fix_lo;
  logic [CNT_W-1:0]   cnt_q;
  logic               pneg_q, rneg_q, op_div_q, divzero_q, done_q;
  logic               accept, is_signed, is_div_code, sa, sb, last_iter, mul_last, step_bit;
  step_mode_e         step_mode;

  always_comb begin
    is_signed   = (bus.alucontrol == FN_MULT) || (bus.alucontrol == FN_DIV);
    is_div_code = (bus.alucontrol == FN_DIV) || (bus.alucontrol == FN_DIVU);
    sa          = is_signed & bus.srca[WIDTH-1];
    sb          = is_signed & bus.srcb[WIDTH-1];
    abs_a       = sa ? -bus.srca : bus.srca;
    abs_b       = sb ? -bus.srcb : bus.srcb;
    accept      = (state_q == ST_IDLE) && bus.start && is_muldiv(bus.alucontrol);
    last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_TERM_EN
    mul_last    = last_iter || (mplr_q[WIDTH-1:1] == '0);
`else
    mul_last    = last_iter;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_n = is_div_code ? ST_DIV : ST_MUL;
      ST_MUL:  if (mul_last) state_n = ST_FIX;
      ST_DIV:  if (last_iter) state_n = ST_FIX;
      ST_FIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    step_mode = (state_q == ST_DIV) ? SM_DIV : SM_MUL;
    step_opnd = ((state_q == ST_DIV) || mplr_q[0]) ? opnd_q : '0;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (step_opnd),
    .mode     (step_mode),
    .acc_next (step_acc),
    .qbit     (step_bit)
  );

  always_comb begin
    prod   = pneg_q ? -acc_q : acc_q;
    quo    = pneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_div_q) begin
      fix_hi = rem;
      fix_lo = divzero_q ? {WIDTH{DIVZERO_LO_BIT}} : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      mplr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      pneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      op_div_q  <= 1'b0;
      divzero_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == ST_FIX);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q     <= '0;
            pneg_q    <= sa ^ sb;
            rneg_q    <= sa;
            op_div_q  <= is_div_code;
            divzero_q <= (bus.srcb == '0);
            if (is_div_code) begin
              acc_q  <= {{WIDTH{1'b0}}, abs_a};
              opnd_q <= {{WIDTH{1'b0}}, abs_b};
              mplr_q <= '0;
            end else begin
              acc_q  <= '0;
              opnd_q <= {{WIDTH{1'b0}}, abs_a};
              mplr_q <= abs_b;
            end
          end else if (bus.start && (bus.alucontrol == FN_MTHI)) begin
            hi_q <= bus.srca;
          end else if (bus.start && (bus.alucontrol == FN_MTLO)) begin
            lo_q <= bus.srca;
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q  <= {step_acc[2*WIDTH-1:1], (state_q == ST_DIV) ? step_bit : step_acc[0]};
          opnd_q <= (state_q == ST_MUL) ? (opnd_q << 1) : opnd_q;
          mplr_q <= mplr_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy   = (state_q != ST_IDLE);
    bus.done   = done_q;
    bus.stall  = bus.start && (state_q != ST_IDLE) && is_known(bus.alucontrol);
    bus.hi     = hi_q;
    bus.lo     = lo_q;
    bus.result = '0;
    if (bus.alucontrol == FN_MFHI)      bus.result = hi_q;
    else if (bus.alucontrol == FN_MFLO) bus.result = lo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, multi-cycle
// stall/reset sequences and randomized ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   passed = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the architectural HI/LO pair.
  task automatic model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sq, sr;
    case (fn)
      FN_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {mhi, mlo} = sp;
      end
      FN_MULTU: begin
        up = 64'(a) * 64'(b);
        {mhi, mlo} = up;
      end
      FN_DIV: begin
        if (b == 0) begin mhi = a; mlo = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin mlo = a; mhi = 0; end
        else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          mlo = sq; mhi = sr;
        end
      end
      FN_DIVU: begin
        if (b == 0) begin mhi = a; mlo = 32'hFFFFFFFF; end
        else begin mlo = a / b; mhi = a % b; end
      end
      FN_MTHI: mhi = a;
      FN_MTLO: mlo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    bus.start = 1'b1; bus.alucontrol = fn; bus.srca = a; bus.srcb = b;
    tick();
    bus.start = 1'b0; bus.alucontrol = 6'h00;
    lat = 0;
    busy_n = bus.busy ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.busy) busy_n++;
      if (bus.done) begin lat = k; break; end
    end
    chk("done_seen", 32'(lat > 0), 32'd1);
    tick();
    chk("done_one_pulse", 32'(bus.done), 32'd0);
  endtask

  vec_t vecs[12];
  logic [5:0] rfn[6];

  initial begin
    int lat, bn, bad;
    logic [31:0] ra, rb;

    vecs[0]  = '{FN_MULT,  32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{FN_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{FN_DIV,   32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{FN_DIVU,  32'd7,          32'd2,        32'd1,        32'd3};
    vecs[4]  = '{FN_DIV,   32'd5,          32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[5]  = '{FN_DIV,   32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[6]  = '{FN_DIVU,  32'h80000000,   32'd0,        32'h80000000, 32'hFFFFFFFF};
    vecs[7]  = '{FN_MULT,  32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{FN_DIV,   32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9]  = '{FN_MULTU, 32'h12345678,   32'h10,       32'd1,        32'h23456780};
    vecs[10] = '{FN_MULT,  32'd5,          32'd0,        32'd0,        32'd0};
    vecs[11] = '{FN_DIVU,  32'hFFFFFFFF,   32'h10,       32'h0000000F, 32'h0FFFFFFF};
    rfn = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO};

    reset = 1'b1;
    bus.start = 1'b0; bus.alucontrol = 6'h00; bus.srca = '0; bus.srcb = '0;
    tick(); tick();
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_done",  32'(bus.done),  32'd0);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_op(vecs[i].fn, vecs[i].a, vecs[i].b, lat, bn);
      chk("vec_hi", bus.hi, vecs[i].exp_hi);
      chk("vec_lo", bus.lo, vecs[i].exp_lo);
`ifdef MULDIV_EARLY_TERM_EN
      if (vecs[i].fn == FN_DIV || vecs[i].fn == FN_DIVU) chk("div_latency", 32'(lat), 32'd33);
      else chk("mul_latency_bounded", 32'(lat >= 2 && lat <= 33), 32'd1);
`else
      chk("latency", 32'(lat), 32'd33);
      chk("busy_cycles", 32'(bn), 32'd33);
`endif
      bus.start = 1'b1; bus.alucontrol = FN_MFHI; #1;
      chk("mfhi_result", bus.result, vecs[i].exp_hi);
      chk("idle_no_stall", 32'(bus.stall), 32'd0);
      bus.alucontrol = FN_MFLO; #1;
      chk("mflo_result", bus.result, vecs[i].exp_lo);
      bus.start = 1'b0; bus.alucontrol = 6'h00;
    end

    // MFLO held while a MULT is in flight must stall every busy cycle.
    bus.start = 1'b1; bus.alucontrol = FN_MULT; bus.srca = 32'd3; bus.srcb = 32'd4;
    tick();
    bus.alucontrol = FN_MFLO; #1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (bus.done) break;
      if (!bus.stall || !bus.busy) bad++;
      tick();
    end
    chk("stall_while_busy", 32'(bad), 32'd0);
    chk("done_after_stall", 32'(bus.done), 32'd1);
    chk("stall_after_done", 32'(bus.stall), 32'd0);
    chk("mflo_fresh", bus.result, 32'd12);
    tick();
    bus.start = 1'b0; bus.alucontrol = 6'h00;
    tick();

    // A second MULT held during busy is only taken after the first completes.
    bus.start = 1'b1; bus.alucontrol = FN_MULT; bus.srca = 32'd3; bus.srcb = 32'd4;
    tick();
    bus.srca = 32'd5; bus.srcb = 32'd6;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.done) begin lat = k; break; end
    end
    chk("first_mult_lo", bus.lo, 32'd12);
    chk("first_mult_hi", bus.hi, 32'd0);
`ifndef MULDIV_EARLY_TERM_EN
    chk("held_start_latency", 32'(lat), 32'd33);
`endif
    tick();
    chk("held_start_accepted", 32'(bus.busy), 32'd1);
    bus.start = 1'b0; bus.alucontrol = 6'h00;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.done) begin lat = k; break; end
    end
    chk("second_mult_done", 32'(lat > 0), 32'd1);
    chk("second_mult_lo", bus.lo, 32'd30);
    tick();

    // Reset in the middle of a divide aborts it with no HI/LO write.
    bus.start = 1'b1; bus.alucontrol = FN_DIV; bus.srca = 32'd100; bus.srcb = 32'd7;
    tick();
    bus.start = 1'b0; bus.alucontrol = 6'h00;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done || bus.busy || bus.lo != 0) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    bus.start = 1'b1; bus.alucontrol = FN_MTLO; bus.srca = 32'h1234;
    tick();
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h1234);
    chk("mtlo_no_busy", 32'(bus.busy), 32'd0);
    chk("mtlo_no_done", 32'(bus.done), 32'd0);
    bus.start = 1'b1; bus.alucontrol = FN_MTHI; bus.srca = 32'hABCD;
    tick();
    bus.start = 1'b0;
    chk("mthi_hi", bus.hi, 32'hABCD);
    chk("mthi_no_done", 32'(bus.done), 32'd0);
    bus.start = 1'b1; bus.alucontrol = 6'b100000; #1;
    chk("other_code_result", bus.result, 32'd0);
    chk("other_code_no_stall", 32'(bus.stall), 32'd0);
    bus.alucontrol = FN_MFHI; #1;
    chk("mfhi_after_mthi", bus.result, 32'hABCD);
    bus.start = 1'b0; bus.alucontrol = 6'h00;
    mhi = 32'hABCD; mlo = 32'h1234;

    for (int i = 0; i < 60; i++) begin
      logic [5:0] fn;
      fn = rfn[$urandom_range(0, 5)];
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(0, 15);
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      if (fn == FN_MTHI || fn == FN_MTLO) begin
        bus.start = 1'b1; bus.alucontrol = fn; bus.srca = ra; bus.srcb = rb;
        tick();
        bus.start = 1'b0; bus.alucontrol = 6'h00;
      end else begin
        run_op(fn, ra, rb, lat, bn);
      end
      model(fn, ra, rb);
      chk("rand_hi", bus.hi, mhi);
      chk("rand_lo", bus.lo, mlo);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
